// File: rtl/generic_2clk_fifo_pkg.sv
// Shared definitions for the generic_2clk_fifo family read-side blocks.
package generic_2clk_fifo_pkg;

    // Read-side arbiter states.
    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Default maximum consecutive pops per grant.
    localparam int unsigned BURST_DEFAULT = 4;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/generic_2clk_fifo_rd_skid.sv
// Two-entry {data, src} output buffer with valid/ready drain and occupancy
// exposed to the arbiter for its credit check.
module generic_2clk_fifo_rd_skid
    import generic_2clk_fifo_pkg::*;
#(
    parameter int unsigned DAT_WIDTH = 40,
    parameter int unsigned SRC_W     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [DAT_WIDTH-1:0] push_data_i,
    input  logic [SRC_W-1:0]     push_src_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [DAT_WIDTH-1:0] data_o,
    output logic [SRC_W-1:0]     src_o,
    output logic [1:0]           occ_o
);

    logic [DAT_WIDTH-1:0] data_q [2];
    logic [SRC_W-1:0]     src_q  [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           occ_q;
    logic                 pop;

    assign valid_o = (occ_q != 2'd0);
    assign pop     = valid_o && ready_i;
    assign data_o  = data_q[rd_ptr_q];
    assign src_o   = src_q[rd_ptr_q];
    assign occ_o   = occ_q;

    // Ring of two entries; the arbiter's credit check guarantees no push when full.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            src_q[0]  <= '0;
            src_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= '0;
        end else begin
            if (push_i) begin
                data_q[wr_ptr_q] <= push_data_i;
                src_q[wr_ptr_q]  <= push_src_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/generic_2clk_fifo_rd_arb.sv
// Read-domain round-robin scheduler sharing one valid/ready consumer between
// NUM_REQ dual-clock FIFOs, with bounded bursts and a credit-checked
// 2-entry output buffer that absorbs the one-cycle RAM read latency.
module generic_2clk_fifo_rd_arb
    import generic_2clk_fifo_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DAT_WIDTH = 40,
    parameter int unsigned BURST     = BURST_DEFAULT,
    parameter int unsigned SRC_W     = clog2(NUM_REQ)
) (
    input  logic                         rd_clk,
    input  logic                         rd_reset,
    input  logic                         arb_en,
    input  logic [NUM_REQ-1:0]           fifo_rd_empty,
    output logic [NUM_REQ-1:0]           fifo_rd_op,
    input  logic [NUM_REQ*DAT_WIDTH-1:0] fifo_rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DAT_WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]             out_src,
    output logic                         busy
);

    arb_state_e           state_q, state_d;
    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]     grant_q, grant_d;
    logic [3:0]           burst_cnt_q, burst_cnt_d;
    logic                 inflight_q;
    logic [SRC_W-1:0]     inflight_src_q;

    logic [1:0]           occ;
    logic                 credit;
    logic                 pop_en;
    logic [SRC_W-1:0]     pop_idx;
    logic                 rr_found;
    logic [SRC_W-1:0]     rr_sel;
    logic [SRC_W-1:0]     cand;
    logic [SRC_W-1:0]     grant_inc;
    logic [DAT_WIDTH-1:0] cap_data;

    // Credit only counts registered occupancy, so out_ready never reaches rd_op.
    assign credit    = (occ + {1'b0, inflight_q}) < 2'd2;
    assign grant_inc = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
    assign busy      = (state_q == ARB_BURST) || inflight_q || (occ != 2'd0);

    // Round-robin search: first non-empty FIFO at or above rr_ptr, with wrap.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = rr_ptr_q;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = SRC_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!rr_found && !fifo_rd_empty[cand]) begin
                rr_found = 1'b1;
                rr_sel   = cand;
            end
        end
    end

    // Next-state and rd_op decode; a held reset suppresses any pop.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        pop_en      = 1'b0;
        pop_idx     = grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (arb_en && rr_found && credit && !rd_reset) begin
                    pop_en      = 1'b1;
                    pop_idx     = rr_sel;
                    grant_d     = rr_sel;
                    burst_cnt_d = 4'd1;
                    state_d     = ARB_BURST;
                end
            end
            ARB_BURST: begin
                if (!arb_en || fifo_rd_empty[grant_q] || (burst_cnt_q >= 4'(BURST))) begin
                    state_d     = ARB_IDLE;
                    rr_ptr_d    = grant_inc;
                    burst_cnt_d = '0;
                end else if (credit && !rd_reset) begin
                    pop_en      = 1'b1;
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        fifo_rd_op = '0;
        if (pop_en) begin
            fifo_rd_op[pop_idx] = 1'b1;
        end
    end

    // State, round-robin pointer and in-flight tracking registers.
    always_ff @(posedge rd_clk) begin
        if (rd_reset) begin
            state_q        <= ARB_IDLE;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            burst_cnt_q    <= '0;
            inflight_q     <= 1'b0;
            inflight_src_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_q        <= grant_d;
            burst_cnt_q    <= burst_cnt_d;
            inflight_q     <= pop_en;
            inflight_src_q <= pop_idx;
        end
    end

    // Select the read-data slice of the FIFO popped in the previous cycle.
    always_comb begin
        cap_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(inflight_src_q) == i) begin
                cap_data = fifo_rd_data[i*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

    generic_2clk_fifo_rd_skid #(
        .DAT_WIDTH(DAT_WIDTH),
        .SRC_W    (SRC_W)
    ) u_skid (
        .clk_i      (rd_clk),
        .rst_i      (rd_reset),
        .push_i     (inflight_q),
        .push_data_i(cap_data),
        .push_src_i (inflight_src_q),
        .ready_i    (out_ready),
        .valid_o    (out_valid),
        .data_o     (out_data),
        .src_o      (out_src),
        .occ_o      (occ)
    );

endmodule
